// File: rtl/processor_pkg.sv
// Shared constants for the multi-cycle processor: opcodes, FSM states, bus
// select codes and ALU op encodings (the ALU op codes are also used by arithmetic_logic_unit).
package processor_pkg;

  localparam int IW   = 9;
  localparam int NREG = 8;
  localparam int SELW = 4;
  localparam int REGW = 3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [SELW-1:0] SEL_DIN = 4'd8;
  localparam logic [SELW-1:0] SEL_G   = 4'd9;

  localparam logic [1:0] ADD_SUB     = 2'b00;
  localparam logic [1:0] LOGICAL_AND = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  // Instruction classes as the sequencer sees them; reserved opcodes decode to CLS_NOP.
  typedef enum logic [1:0] {
    CLS_MV  = 2'd0,
    CLS_MVI = 2'd1,
    CLS_ALU = 2'd2,
    CLS_NOP = 2'd3
  } op_class_t;

endpackage

// File: rtl/processor_instr_decoder.sv
// Combinational decode of the held instruction register into sequencer class,
// register fields and the ALU controls.
module processor_instr_decoder
  import processor_pkg::*;
#(
  parameter int IW   = processor_pkg::IW,
  parameter int NREG = processor_pkg::NREG
) (
  input  logic [IW-1:0]   ir,
  output op_class_t       op_class,
  output logic [REGW-1:0] rx,
  output logic [NREG-1:0] rx_onehot,
  output logic [REGW-1:0] ry,
  output logic [1:0]      alu_op,
  output logic            add_sub_control,
  output logic            cin
);

  logic [2:0] opcode;

  assign opcode    = ir[IW-1 -: 3];
  assign rx        = ir[2*REGW-1 -: REGW];
  assign ry        = ir[REGW-1:0];
  assign rx_onehot = NREG'(1) << rx;

  always_comb begin
    op_class        = CLS_NOP;
    alu_op          = ADD_SUB;
    add_sub_control = 1'b0;
    cin             = 1'b0;
    case (opcode)
      OP_MV:  op_class = CLS_MV;
      OP_MVI: op_class = CLS_MVI;
      OP_ADD: op_class = CLS_ALU;
      OP_SUB: begin
        op_class        = CLS_ALU;
        add_sub_control = 1'b1;
        cin             = 1'b1;
      end
      OP_AND: begin
        op_class = CLS_ALU;
        alu_op   = LOGICAL_AND;
      end
      default: op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/processor_control_unit.sv
// Multi-cycle instruction sequencer: captures an instruction on run and steps
// the datapath controls through T1..T3; carries no data bits itself.
module processor_control_unit
  import processor_pkg::*;
#(
  parameter int IW   = processor_pkg::IW,
  parameter int NREG = processor_pkg::NREG,
  parameter int SELW = processor_pkg::SELW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [IW-1:0]   instr,
  output logic            ir_load,
  output logic [SELW-1:0] bus_sel,
  output logic [NREG-1:0] reg_in,
  output logic            a_in,
  output logic            g_in,
  output logic [1:0]      alu_op,
  output logic            add_sub_control,
  output logic            cin,
  output logic            done,
  output logic [1:0]      state_dbg
);

  // Handshake: run is a start request sampled only in IDLE; the instruction is
  // accepted on the edge where ir_load=1, and done=1 marks the final step of it.

  state_t          state, next_state;
  logic [IW-1:0]   ir;
  op_class_t       op_class;
  logic [REGW-1:0] rx, ry;
  logic [NREG-1:0] rx_onehot;

  processor_instr_decoder #(.IW(IW), .NREG(NREG)) u_decoder (
    .ir              (ir),
    .op_class        (op_class),
    .rx              (rx),
    .rx_onehot       (rx_onehot),
    .ry              (ry),
    .alu_op          (alu_op),
    .add_sub_control (add_sub_control),
    .cin             (cin)
  );

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (ir_load) ir <= instr;
    end
  end

  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    bus_sel    = '0;
    reg_in     = '0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // Reset outranks run, so no capture is advertised while it is held.
        ir_load = run & ~reset;
        if (run) next_state = T1;
      end
      T1: begin
        next_state = IDLE;
        case (op_class)
          CLS_MV: begin
            bus_sel = SELW'(ry);
            reg_in  = rx_onehot;
            done    = 1'b1;
          end
          CLS_MVI: begin
            bus_sel = SEL_DIN;
            reg_in  = rx_onehot;
            done    = 1'b1;
          end
          CLS_ALU: begin
            bus_sel    = SELW'(rx);
            a_in       = 1'b1;
            next_state = T2;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        bus_sel    = SELW'(ry);
        g_in       = 1'b1;
        next_state = T3;
      end
      T3: begin
        bus_sel    = SEL_G;
        reg_in     = rx_onehot;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
